vedm_multichannel_voltage_scaler: RTL and testbench

//  Parametrised successor to the single-channel x2 voltage converter. Accepts time-multiplexed

---
 rtl/vedm_multichannel_voltage_scaler.sv | 145 ++++++++++++++
 tb/tb_vedm_multichannel_voltage_scaler.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vedm_multichannel_voltage_scaler.sv
// vedm_multichannel_voltage_scaler
//
// Takes time-multiplexed samples from CHANNELS sources and scales each one by a
// per-sample gain. The product is shifted right by SHIFT and saturated to DATA_W
// bits. The scaled samples of each channel are averaged over blocks of
// 2**AVG_LOG2 samples, and the block average is emitted once per block.
//
// Ports
//   clk       clock, rising edge
//   rst_n     asynchronous active-low reset
//   ena       global enable; low freezes all registers
//   clr       synchronous clear of accumulators, counters, sat_flag, stage 1
//   in_valid  sample strobe (accepted when in_valid & ena)
//   in_ch     sample channel; values >= CHANNELS are dropped
//   in_data   raw unsigned sample
//   gain      unsigned gain, sampled with in_data
//   out_valid one-cycle strobe for a new average
//   out_ch    channel of the average
//   out_data  averaged, scaled, saturated value
//   sat_flag  sticky saturation indicator since reset/clr

module vedm_multichannel_voltage_scaler #(
    parameter int DATA_W   = 8,
    parameter int GAIN_W   = 4,
    parameter int SHIFT    = 1,
    parameter int CHANNELS = 4,
    parameter int AVG_LOG2 = 2,
    localparam int CH_W    = $clog2(CHANNELS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic              clr,
    input  logic              in_valid,
    input  logic [CH_W-1:0]   in_ch,
    input  logic [DATA_W-1:0] in_data,
    input  logic [GAIN_W-1:0] gain,
    output logic              out_valid,
    output logic [CH_W-1:0]   out_ch,
    output logic [DATA_W-1:0] out_data,
    output logic              sat_flag
);

    localparam int PROD_W = DATA_W + GAIN_W;
    localparam int ACC_W  = DATA_W + AVG_LOG2;
    // A zero-width counter is not legal; with AVG_LOG2 = 0 the single counter
    // bit stays 0 and every sample completes its own block.
    localparam int CNT_W  = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    // The storage is sized to the full index range, so a dynamic index never
    // reads outside the array.
    localparam int NSLOT  = 1 << CH_W;

    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'((1 << AVG_LOG2) - 1);
    localparam logic [PROD_W-1:0] DATA_MAX = PROD_W'((1 << DATA_W) - 1);

    // stage 1
    logic              s1_valid;
    logic [PROD_W-1:0] s1_prod;
    logic [CH_W-1:0]   s1_ch;

    // per-channel block state
    logic [ACC_W-1:0]  acc [NSLOT];
    logic [CNT_W-1:0]  cnt [NSLOT];

    logic              ch_ok;
    logic [PROD_W-1:0] scaled_full;
    logic              sat_now;
    logic [DATA_W-1:0] scaled;
    logic [ACC_W-1:0]  acc_sum;
    logic              block_done;
    logic [DATA_W-1:0] avg;

    // The channel index is widened by one bit so that CHANNELS itself can be
    // represented even when it is a power of two.
    assign ch_ok = ({1'b0, in_ch} < (CH_W + 1)'(CHANNELS));

    always_comb begin
        scaled_full = s1_prod >> SHIFT;
        sat_now     = (scaled_full > DATA_MAX);
        scaled      = sat_now ? {DATA_W{1'b1}} : scaled_full[DATA_W-1:0];
        // acc holds at most (2**AVG_LOG2 - 1) full-scale samples, so adding one
        // more sample always fits in ACC_W bits.
        acc_sum     = acc[s1_ch] + ACC_W'(scaled);
        block_done  = (cnt[s1_ch] == CNT_LAST);
        avg         = DATA_W'(acc_sum >> AVG_LOG2);
    end

    // Stage 1: capture product, channel and valid
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_prod  <= '0;
            s1_ch    <= '0;
        end else if (ena) begin
            if (clr) begin
                s1_valid <= 1'b0;
            end else begin
                s1_valid <= in_valid & ch_ok;
                s1_prod  <= PROD_W'(in_data) * PROD_W'(gain);
                s1_ch    <= in_ch;
            end
        end
    end

    // Stage 2: saturate, accumulate, emit block average
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NSLOT; i++) begin
                acc[i] <= '0;
                cnt[i] <= '0;
            end
            out_valid <= 1'b0;
            out_ch    <= '0;
            out_data  <= '0;
            sat_flag  <= 1'b0;
        end else if (ena) begin
            if (clr) begin
                for (int i = 0; i < NSLOT; i++) begin
                    acc[i] <= '0;
                    cnt[i] <= '0;
                end
                out_valid <= 1'b0;
                sat_flag  <= 1'b0;
            end else begin
                out_valid <= 1'b0;
                if (s1_valid) begin
                    if (sat_now) begin
                        sat_flag <= 1'b1;
                    end
                    if (block_done) begin
                        out_valid   <= 1'b1;
                        out_ch      <= s1_ch;
                        out_data    <= avg;
                        acc[s1_ch]  <= '0;
                        cnt[s1_ch]  <= '0;
                    end else begin
                        acc[s1_ch]  <= acc_sum;
                        cnt[s1_ch]  <= cnt[s1_ch] + 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_vedm_multichannel_voltage_scaler.sv
module tb_vedm_multichannel_voltage_scaler;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b1;
    logic       clr = 1'b0;
    logic       in_valid = 1'b0;
    logic [1:0] in_ch = 2'd0;
    logic [7:0] in_data = 8'd0;
    logic [3:0] gain = 4'd0;

    logic       out_valid, sat_flag;
    logic [1:0] out_ch;
    logic [7:0] out_data;

    logic       out_valid3, sat_flag3;
    logic [1:0] out_ch3;
    logic [7:0] out_data3;

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;

    int q_ch[$];
    int q_data[$];
    int q_cyc[$];
    int q3_ch[$];
    int q3_data[$];

    vedm_multichannel_voltage_scaler #(
        .DATA_W(8), .GAIN_W(4), .SHIFT(1), .CHANNELS(4), .AVG_LOG2(2)
    ) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .clr(clr),
        .in_valid(in_valid), .in_ch(in_ch), .in_data(in_data), .gain(gain),
        .out_valid(out_valid), .out_ch(out_ch), .out_data(out_data), .sat_flag(sat_flag)
    );

    vedm_multichannel_voltage_scaler #(
        .DATA_W(8), .GAIN_W(4), .SHIFT(1), .CHANNELS(3), .AVG_LOG2(2)
    ) dut3 (
        .clk(clk), .rst_n(rst_n), .ena(ena), .clr(clr),
        .in_valid(in_valid), .in_ch(in_ch), .in_data(in_data), .gain(gain),
        .out_valid(out_valid3), .out_ch(out_ch3), .out_data(out_data3), .sat_flag(sat_flag3)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (out_valid === 1'b1) begin
            q_ch.push_back(int'(out_ch));
            q_data.push_back(int'(out_data));
            q_cyc.push_back(cyc);
        end
        if (out_valid3 === 1'b1) begin
            q3_ch.push_back(int'(out_ch3));
            q3_data.push_back(int'(out_data3));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] ch, input logic [7:0] d, input logic [3:0] g);
        in_valid = 1'b1;
        in_ch    = ch;
        in_data  = d;
        gain     = g;
        step();
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) step();
    endtask

    task automatic clear_logs();
        q_ch.delete();
        q_data.delete();
        q_cyc.delete();
        q3_ch.delete();
        q3_data.delete();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        in_data = 8'd77;
        gain = 4'd3;
        in_valid = 1'b1;
        repeat (3) step();
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %0d expected 0", out_valid); end
        n_cmp++; if (out_ch !== 2'd0) begin n_fail++; $display("FAIL reset_out_ch: got %0d expected 0", out_ch); end
        n_cmp++; if (out_data !== 8'd0) begin n_fail++; $display("FAIL reset_out_data: got %0d expected 0", out_data); end
        n_cmp++; if (sat_flag !== 1'b0) begin n_fail++; $display("FAIL reset_sat_flag: got %0d expected 0", sat_flag); end
        in_valid = 1'b0;
        rst_n = 1'b1;
        idle(2);
        n_cmp++; if (q_ch.size() != 0) begin n_fail++; $display("FAIL reset_no_output: got %0d outputs expected 0", q_ch.size()); end
    endtask

    task automatic test_basic_average();
        int k4;
        clear_logs();
        drive(2'd0, 8'd10, 4'd4);
        drive(2'd0, 8'd20, 4'd4);
        drive(2'd0, 8'd30, 4'd4);
        k4 = cyc;
        drive(2'd0, 8'd40, 4'd4);
        idle(3);
        n_cmp++; if (q_ch.size() != 1) begin n_fail++; $display("FAIL basic_count: got %0d outputs expected 1", q_ch.size()); end
        if (q_ch.size() >= 1) begin
            n_cmp++; if (q_ch[0] != 0) begin n_fail++; $display("FAIL basic_ch: got %0d expected 0", q_ch[0]); end
            n_cmp++; if (q_data[0] != 50) begin n_fail++; $display("FAIL basic_data: got %0d expected 50", q_data[0]); end
            n_cmp++; if (q_cyc[0] != k4 + 2) begin n_fail++; $display("FAIL basic_latency: got cycle %0d expected %0d", q_cyc[0], k4 + 2); end
        end
        n_cmp++; if (sat_flag !== 1'b0) begin n_fail++; $display("FAIL basic_sat: got %0d expected 0", sat_flag); end
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_strobe_one_cycle: got %0d expected 0", out_valid); end
        n_cmp++; if (out_data !== 8'd50) begin n_fail++; $display("FAIL basic_hold: got %0d expected 50", out_data); end
    endtask

    task automatic test_saturation();
        clear_logs();
        repeat (4) drive(2'd3, 8'd200, 4'd15);
        idle(3);
        n_cmp++; if (q_ch.size() != 1) begin n_fail++; $display("FAIL sat_count: got %0d outputs expected 1", q_ch.size()); end
        if (q_ch.size() >= 1) begin
            n_cmp++; if (q_ch[0] != 3) begin n_fail++; $display("FAIL sat_ch: got %0d expected 3", q_ch[0]); end
            n_cmp++; if (q_data[0] != 255) begin n_fail++; $display("FAIL sat_data: got %0d expected 255", q_data[0]); end
        end
        n_cmp++; if (sat_flag !== 1'b1) begin n_fail++; $display("FAIL sat_flag_set: got %0d expected 1", sat_flag); end
        clear_logs();
        repeat (4) drive(2'd3, 8'd10, 4'd2);
        idle(3);
        n_cmp++; if (q_data.size() != 1 || q_data[0] != 10) begin n_fail++; $display("FAIL sat_followup_data: got %0d outputs first %0d expected 1 output of 10", q_data.size(), (q_data.size() > 0) ? q_data[0] : -1); end
        n_cmp++; if (sat_flag !== 1'b1) begin n_fail++; $display("FAIL sat_flag_sticky: got %0d expected 1", sat_flag); end
        clr = 1'b1;
        step();
        clr = 1'b0;
        n_cmp++; if (sat_flag !== 1'b0) begin n_fail++; $display("FAIL sat_flag_clr: got %0d expected 0", sat_flag); end
    endtask

    task automatic test_interleave();
        clear_logs();
        for (int i = 0; i < 4; i++) begin
            drive(2'd0, 8'd8, 4'd2);
            drive(2'd1, 8'd100, 4'd2);
        end
        idle(3);
        n_cmp++; if (q_ch.size() != 2) begin n_fail++; $display("FAIL ilv_count: got %0d outputs expected 2", q_ch.size()); end
        if (q_ch.size() >= 2) begin
            n_cmp++; if (q_ch[0] != 0 || q_data[0] != 8) begin n_fail++; $display("FAIL ilv_first: got ch %0d data %0d expected ch 0 data 8", q_ch[0], q_data[0]); end
            n_cmp++; if (q_ch[1] != 1 || q_data[1] != 100) begin n_fail++; $display("FAIL ilv_second: got ch %0d data %0d expected ch 1 data 100", q_ch[1], q_data[1]); end
            n_cmp++; if (q_cyc[1] != q_cyc[0] + 1) begin n_fail++; $display("FAIL ilv_spacing: got cycles %0d,%0d expected consecutive", q_cyc[0], q_cyc[1]); end
        end
    endtask

    task automatic test_clr();
        clear_logs();
        drive(2'd2, 8'd4, 4'd2);
        drive(2'd2, 8'd4, 4'd2);
        clr = 1'b1;
        drive(2'd2, 8'd99, 4'd2);
        clr = 1'b0;
        repeat (4) drive(2'd2, 8'd16, 4'd2);
        idle(3);
        n_cmp++; if (q_ch.size() != 1) begin n_fail++; $display("FAIL clr_count: got %0d outputs expected 1", q_ch.size()); end
        if (q_ch.size() >= 1) begin
            n_cmp++; if (q_ch[0] != 2 || q_data[0] != 16) begin n_fail++; $display("FAIL clr_out: got ch %0d data %0d expected ch 2 data 16", q_ch[0], q_data[0]); end
        end
        n_cmp++; if (sat_flag !== 1'b0) begin n_fail++; $display("FAIL clr_sat: got %0d expected 0", sat_flag); end
    endtask

    task automatic test_enable_freeze();
        logic [7:0] d0;
        logic [1:0] c0;
        clear_logs();
        drive(2'd1, 8'd10, 4'd2);
        drive(2'd1, 8'd20, 4'd2);
        d0 = out_data;
        c0 = out_ch;
        ena = 1'b0;
        clr = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_valid = i[0];
            in_ch = 2'd1;
            in_data = 8'd200;
            gain = 4'd2;
            step();
            n_cmp++; if (out_valid !== 1'b0 || out_data !== d0 || out_ch !== c0) begin n_fail++; $display("FAIL ena_freeze: got valid %0d ch %0d data %0d expected 0/%0d/%0d", out_valid, out_ch, out_data, c0, d0); end
        end
        clr = 1'b0;
        in_valid = 1'b0;
        ena = 1'b1;
        drive(2'd1, 8'd30, 4'd2);
        drive(2'd1, 8'd40, 4'd2);
        idle(3);
        n_cmp++; if (q_ch.size() != 1) begin n_fail++; $display("FAIL ena_count: got %0d outputs expected 1", q_ch.size()); end
        if (q_ch.size() >= 1) begin
            n_cmp++; if (q_ch[0] != 1 || q_data[0] != 25) begin n_fail++; $display("FAIL ena_out: got ch %0d data %0d expected ch 1 data 25", q_ch[0], q_data[0]); end
        end
    endtask

    task automatic test_reset_midblock();
        clear_logs();
        drive(2'd0, 8'd100, 4'd2);
        drive(2'd0, 8'd100, 4'd2);
        rst_n = 1'b0;
        #2;
        n_cmp++; if (out_valid !== 1'b0 || out_ch !== 2'd0 || out_data !== 8'd0 || sat_flag !== 1'b0) begin n_fail++; $display("FAIL midreset_outputs: got %0d/%0d/%0d/%0d expected all 0", out_valid, out_ch, out_data, sat_flag); end
        rst_n = 1'b1;
        drive(2'd0, 8'd8, 4'd2);
        drive(2'd0, 8'd8, 4'd2);
        idle(3);
        n_cmp++; if (q_ch.size() != 0) begin n_fail++; $display("FAIL midreset_partial_lost: got %0d outputs expected 0", q_ch.size()); end
        drive(2'd0, 8'd8, 4'd2);
        drive(2'd0, 8'd8, 4'd2);
        idle(3);
        n_cmp++; if (q_ch.size() != 1 || (q_data.size() > 0 && q_data[0] != 8)) begin n_fail++; $display("FAIL midreset_full_block: got %0d outputs first %0d expected 1 output of 8", q_data.size(), (q_data.size() > 0) ? q_data[0] : -1); end
    endtask

    task automatic test_invalid_channel();
        clear_logs();
        repeat (8) drive(2'd3, 8'd50, 4'd2);
        idle(3);
        n_cmp++; if (q3_ch.size() != 0) begin n_fail++; $display("FAIL badch_dropped: got %0d outputs expected 0", q3_ch.size()); end
        repeat (4) drive(2'd2, 8'd60, 4'd2);
        idle(3);
        n_cmp++; if (q3_ch.size() != 1) begin n_fail++; $display("FAIL badch_valid_count: got %0d outputs expected 1", q3_ch.size()); end
        if (q3_ch.size() >= 1) begin
            n_cmp++; if (q3_ch[0] != 2 || q3_data[0] != 60) begin n_fail++; $display("FAIL badch_valid_out: got ch %0d data %0d expected ch 2 data 60", q3_ch[0], q3_data[0]); end
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_basic_average();
        test_saturation();
        test_interleave();
        test_clr();
        test_enable_freeze();
        test_reset_midblock();
        test_invalid_channel();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
